// File: rtl/ripple_mon_pkg.sv
// Shared definitions for the ripple counter monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ripple_mon_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef logic [CNT_W-1:0] cnt_t;

  // Modulo-16 successor of a counter value.
  function automatic cnt_t cnt_next(input cnt_t v);
    return (v == CNT_MAX) ? cnt_t'(0) : cnt_t'(v + cnt_t'(1));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus that is only sampled after it has settled.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running every edge.
//
// Ports:
//   clk   - sampling clock
//   reset - asynchronous, active-high; clears both stages
//   d     - asynchronous input bus
//   q     - synchronised output (second stage)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Resynchronises a settling ripple-counter bus, accepts stable new values and extends them with a wrap count.
// Latency: STABLE_CYCLES+3 clk edges from first sample of a new stable input to out_valid/out_value.
// Backpressure: single-entry output register; an unconsumed value is overwritten (newest wins) and overrun latches.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset      - asynchronous, active-high
//   cnt_in     - raw 4-bit ripple-counter value, asynchronous to clk
//   out_ready  - consumer accepts out_value when high together with out_valid
//   out_valid  - out_value holds an unconsumed accepted value
//   out_value  - {wrap_count, accepted 4-bit value}, EXT_WIDTH bits
//   wrap_pulse - one-cycle pulse coincident with the load of a wrapped value
//   overrun    - sticky: a value was overwritten before consumption
//   seq_err    - sticky: an accepted value was not the successor of the previous one
//                (present only when RIPPLE_MON_SEQ_CHECK_EN is defined)
//
// Optional feature macro: RIPPLE_MON_SEQ_CHECK_EN
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,   // legal range 2..15
  parameter int EXT_WIDTH     = 12   // minimum 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cnt_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [EXT_WIDTH-1:0] out_value,
  output logic                 wrap_pulse,
  output logic                 overrun
`ifdef RIPPLE_MON_SEQ_CHECK_EN
  ,
  output logic                 seq_err
`endif
);

  localparam int WRAP_W = EXT_WIDTH - CNT_W;
  localparam logic [3:0] STAB_TGT = 4'(STABLE_CYCLES);

  cnt_t              s2;
  cnt_t              cand;
  cnt_t              committed;
  logic [3:0]        stab;
  logic [WRAP_W-1:0] wrap_count;
  logic [WRAP_W-1:0] wrap_next;
  logic              accept;
  logic              is_wrap;

  sync_2ff #(
    .WIDTH(CNT_W)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cnt_in),
    .q    (s2)
  );

  // Accept uses the registered filter state, so a value that reached the
  // stability target is taken even if s2 moves on during the same edge.
  assign accept    = (stab == STAB_TGT) && (cand != committed);
  // Any backwards step means the counter passed through 0 (possibly skipping it).
  assign is_wrap   = (cand < committed);
  assign wrap_next = is_wrap ? wrap_count + WRAP_W'(1) : wrap_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand       <= '0;
      stab       <= '0;
      committed  <= '0;
      wrap_count <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      wrap_pulse <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Stability filter: restart the count on any change, saturate at target.
      if (s2 != cand) begin
        cand <= s2;
        stab <= 4'd1;
      end else if (stab != STAB_TGT) begin
        stab <= stab + 4'd1;
      end

      wrap_pulse <= accept && is_wrap;

      if (accept) begin
        committed  <= cand;
        wrap_count <= wrap_next;
        out_value  <= {wrap_next, cand};
        out_valid  <= 1'b1;
        // A same-edge handshake consumes the old value, so only a stalled
        // consumer counts as an overwrite.
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RIPPLE_MON_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err <= 1'b0;
    end else if (accept && (cand != cnt_next(committed))) begin
      seq_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed self-checking bench for ripple_count_monitor (default parameters).
// Latency: n/a.
// Backpressure: exercised via out_ready.
module tb_ripple_count_monitor;

  logic        clk;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_value;
  logic        wrap_pulse;
  logic        overrun;
`ifdef RIPPLE_MON_SEQ_CHECK_EN
  logic        seq_err;
`endif

  int checks = 0;
  int errors = 0;

  ripple_count_monitor #(
    .STABLE_CYCLES(2),
    .EXT_WIDTH    (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .wrap_pulse(wrap_pulse),
    .overrun   (overrun)
`ifdef RIPPLE_MON_SEQ_CHECK_EN
    ,
    .seq_err   (seq_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present v and wait (bounded) for the report; then advance one more edge.
  task automatic step(input logic [3:0] v, output logic got,
                      output logic [11:0] val, output logic wp);
    got = 1'b0;
    val = '0;
    wp  = 1'b0;
    cnt_in = v;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        got = 1'b1;
        val = out_value;
        wp  = wrap_pulse;
      end
    end
    edge_n(1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cnt_in = 4'h0;
    edge_n(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cnt_in = 4'h0;
    out_ready = 1'b1;
    edge_n(3);
    checks++;
    if ({out_valid, out_value, wrap_pulse, overrun} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, out_value, wrap_pulse, overrun});
    end
`ifdef RIPPLE_MON_SEQ_CHECK_EN
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_seq_err: got %b required 0", seq_err);
    end
`endif
    reset = 1'b0;
    edge_n(4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero_not_reported: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_clean_step();
    out_ready = 1'b1;
    cnt_in = 4'h1;
    for (int e = 1; e <= 4; e++) begin
      edge_n(1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL clean_early_edge%0d: out_valid %b required 0", e, out_valid);
      end
    end
    edge_n(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 12'h001) begin
      errors++;
      $display("FAIL clean_edge5: valid %b value %h required 1 001", out_valid, out_value);
    end
    edge_n(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_one_cycle: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_glitch();
    out_ready = 1'b1;
    cnt_in = 4'h6;
    edge_n(1);
    cnt_in = 4'h1;
    for (int e = 0; e < 8; e++) begin
      edge_n(1);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch_edge%0d: out_valid %b required 0", e, out_valid);
      end
    end
    checks++;
    if (dut.committed !== 4'h1) begin
      errors++;
      $display("FAIL glitch_committed: got %h required 1", dut.committed);
    end
  endtask

  task automatic test_wrap();
    logic got;
    logic [11:0] val;
    logic wp;
    out_ready = 1'b1;
    for (int v = 2; v <= 16; v++) begin
      logic [3:0] nib;
      logic [11:0] exp_val;
      logic exp_wp;
      nib     = 4'(v);
      exp_val = (v == 16) ? 12'h010 : {8'h00, nib};
      exp_wp  = (v == 16);
      step(nib, got, val, wp);
      checks++;
      if (!got || val !== exp_val || wp !== exp_wp) begin
        errors++;
        $display("FAIL wrap_step%0d: got %b value %h wrap_pulse %b required 1 %h %b",
                 v, got, val, wp, exp_val, exp_wp);
      end
    end
    checks++;
    if (wrap_pulse !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse_width: wrap_pulse %b out_valid %b required 0 0", wrap_pulse, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic got;
    logic [11:0] val;
    logic wp;
    out_ready = 1'b0;
    step(4'h1, got, val, wp);
    checks++;
    if (!got || val !== 12'h011) begin
      errors++;
      $display("FAIL bp_first: got %b value %h required 1 011", got, val);
    end
    cnt_in = 4'h2;
    edge_n(4);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 12'h011 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid %b value %h overrun %b required 1 011 0", out_valid, out_value, overrun);
    end
    edge_n(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 12'h012 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overwrite: valid %b value %h overrun %b required 1 012 1", out_valid, out_value, overrun);
    end
    out_ready = 1'b1;
    edge_n(1);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: valid %b overrun %b required 0 1", out_valid, overrun);
    end
  endtask

  task automatic test_simultaneous();
    logic got;
    logic [11:0] val;
    logic wp;
    apply_reset();
    out_ready = 1'b0;
    step(4'h2, got, val, wp);
    checks++;
    if (!got || val !== 12'h002) begin
      errors++;
      $display("FAIL sim_pending: got %b value %h required 1 002", got, val);
    end
    cnt_in = 4'h3;
    edge_n(4);
    out_ready = 1'b1;
    edge_n(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 12'h003 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL sim_accept: valid %b value %h overrun %b required 1 003 0", out_valid, out_value, overrun);
    end
    edge_n(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_drain: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_seq_and_reset();
    logic got;
    logic [11:0] val;
    logic wp;
    apply_reset();
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      step(4'(v), got, val, wp);
      checks++;
      if (!got || val !== {8'h00, 4'(v)}) begin
        errors++;
        $display("FAIL seq_step%0d: got %b value %h required 1 %h", v, got, val, {8'h00, 4'(v)});
      end
    end
`ifdef RIPPLE_MON_SEQ_CHECK_EN
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_err_clean: got %b required 0", seq_err);
    end
`endif
    step(4'h7, got, val, wp);
    checks++;
    if (!got || val !== 12'h007) begin
      errors++;
      $display("FAIL seq_skip_value: got %b value %h required 1 007", got, val);
    end
`ifdef RIPPLE_MON_SEQ_CHECK_EN
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_err_skip: got %b required 1", seq_err);
    end
`endif
    // Build up a pending, overrun state and an in-flight value, then reset mid-cycle.
    out_ready = 1'b0;
    step(4'h8, got, val, wp);
    cnt_in = 4'h9;
    edge_n(5);
    cnt_in = 4'hA;
    edge_n(3);
    checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: valid %b overrun %b required 1 1", out_valid, overrun);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_value, wrap_pulse, overrun} !== 15'h0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {out_valid, out_value, wrap_pulse, overrun});
    end
`ifdef RIPPLE_MON_SEQ_CHECK_EN
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_seq_err: got %b required 0", seq_err);
    end
`endif
    cnt_in = 4'h0;
    out_ready = 1'b1;
    edge_n(2);
    reset = 1'b0;
    edge_n(8);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_zero: out_valid %b required 0", out_valid);
    end
    step(4'h1, got, val, wp);
    checks++;
    if (!got || val !== 12'h001) begin
      errors++;
      $display("FAIL post_reset_first: got %b value %h required 1 001", got, val);
    end
  endtask

  initial begin
    reset = 1'b1;
    cnt_in = 4'h0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_clean_step();
    test_glitch();
    test_wrap();
    test_backpressure();
    test_simultaneous();
    test_seq_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
